// File: rtl/hamming_scrubber.sv
// Two-stage (72,64) SECDED checker/corrector with a single-entry write-back
// request, saturating error counters and sticky error flags.
module hamming_scrubber #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [63:0]      in_data,
    input  logic [7:0]       in_check,
    output logic             out_valid,
    output logic [63:0]      out_data,
    output logic             sbe,
    output logic             dbe,
    output logic             wb_valid,
    output logic [63:0]      wb_data,
    output logic [7:0]       wb_check,
    input  logic             wb_ready,
    input  logic             err_clr,
    output logic [CNT_W-1:0] sbe_count,
    output logic [CNT_W-1:0] dbe_count,
    output logic             dbe_sticky,
    output logic             wb_overrun
);

    typedef enum logic {WB_IDLE, WB_REQ} wb_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Code position (1..71) of data bit k: the k-th non-power-of-two position.
    function automatic int data_pos(input int k);
        int idx;
        int pos;
        idx = 0;
        pos = 0;
        for (int p = 1; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (idx == k) pos = p;
                idx = idx + 1;
            end
        end
        return pos;
    endfunction

    function automatic logic [7:0] calc_check(input logic [63:0] d);
        logic [6:0] c;
        int         k;
        c = '0;
        k = 0;
        for (int p = 1; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                for (int i = 0; i < 7; i++) begin
                    if (((p >> i) & 1) != 0) c[i] = c[i] ^ d[k];
                end
                k = k + 1;
            end
        end
        return {(^d) ^ (^c), c};
    endfunction

    // Stage 1: syndrome, overall parity and raw word
    logic        v1_q;
    logic [6:0]  syn_q;
    logic        par_q;
    logic [63:0] raw_q;
    logic [7:0]  in_calc;
    logic [6:0]  syn_d;
    logic        par_d;

    assign in_calc = calc_check(in_data);
    assign syn_d   = in_calc[6:0] ^ in_check[6:0];
    assign par_d   = (^in_data) ^ (^in_check);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q  <= 1'b0;
            syn_q <= '0;
            par_q <= 1'b0;
            raw_q <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                syn_q <= syn_d;
                par_q <= par_d;
                raw_q <= in_data;
            end
        end
    end

    // Stage 2: classification and correction
    logic [63:0] flip_mask;

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_flip
            localparam int POS = data_pos(gi);
            assign flip_mask[gi] = (syn_q == 7'(POS));
        end
    endgenerate

    logic        sbe_d;
    logic        dbe_d;
    logic [63:0] data_d;

    // flip_mask is all-zero for syndromes that point at a check bit or at 0.
    always_comb begin
        sbe_d  = 1'b0;
        dbe_d  = 1'b0;
        data_d = raw_q;
        if (v1_q) begin
            if (par_q) begin
                if (syn_q > 7'd71) begin
                    dbe_d = 1'b1;
                end else begin
                    sbe_d  = 1'b1;
                    data_d = raw_q ^ flip_mask;
                end
            end else if (syn_q != 7'd0) begin
                dbe_d = 1'b1;
            end
        end
    end

    logic        out_valid_q;
    logic        sbe_q;
    logic        dbe_q;
    logic [63:0] out_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sbe_q       <= 1'b0;
            dbe_q       <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= v1_q;
            sbe_q       <= sbe_d;
            dbe_q       <= dbe_d;
            if (v1_q) out_data_q <= data_d;
        end
    end

    // Write-back request
    wb_state_t   wb_state_q;
    logic        wb_valid_q;
    logic [63:0] wb_data_q;
    logic [7:0]  wb_check_q;
    logic [7:0]  wb_check_d;

    assign wb_check_d = calc_check(out_data_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_state_q <= WB_IDLE;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_check_q <= '0;
        end else begin
            case (wb_state_q)
                WB_IDLE: begin
                    if (sbe_q) begin
                        wb_state_q <= WB_REQ;
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= out_data_q;
                        wb_check_q <= wb_check_d;
                    end
                end
                WB_REQ: begin
                    if (wb_ready) begin
                        wb_state_q <= WB_IDLE;
                        wb_valid_q <= 1'b0;
                    end
                end
                default: begin
                    wb_state_q <= WB_IDLE;
                    wb_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Counters and sticky flags; a same-cycle event wins over err_clr.
    logic [CNT_W-1:0] sbe_cnt_q, sbe_cnt_d;
    logic [CNT_W-1:0] dbe_cnt_q, dbe_cnt_d;
    logic             dbe_sticky_q, dbe_sticky_d;
    logic             ovr_q, ovr_d;
    logic             ovr_evt;

    assign ovr_evt = (wb_state_q == WB_REQ) && sbe_q;

    always_comb begin
        sbe_cnt_d = sbe_cnt_q;
        dbe_cnt_d = dbe_cnt_q;
        if (err_clr) begin
            sbe_cnt_d = sbe_q ? CNT_W'(1) : '0;
            dbe_cnt_d = dbe_q ? CNT_W'(1) : '0;
        end else begin
            if (sbe_q && sbe_cnt_q != CNT_MAX) sbe_cnt_d = sbe_cnt_q + CNT_W'(1);
            if (dbe_q && dbe_cnt_q != CNT_MAX) dbe_cnt_d = dbe_cnt_q + CNT_W'(1);
        end
        dbe_sticky_d = dbe_q | (dbe_sticky_q & ~err_clr);
        ovr_d        = ovr_evt | (ovr_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbe_cnt_q    <= '0;
            dbe_cnt_q    <= '0;
            dbe_sticky_q <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            sbe_cnt_q    <= sbe_cnt_d;
            dbe_cnt_q    <= dbe_cnt_d;
            dbe_sticky_q <= dbe_sticky_d;
            ovr_q        <= ovr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign sbe        = sbe_q;
    assign dbe        = dbe_q;
    assign wb_valid   = wb_valid_q;
    assign wb_data    = wb_data_q;
    assign wb_check   = wb_check_q;
    assign sbe_count  = sbe_cnt_q;
    assign dbe_count  = dbe_cnt_q;
    assign dbe_sticky = dbe_sticky_q;
    assign wb_overrun = ovr_q;

endmodule

// File: doc/hamming_scrubber.md
HAMMING_SCRUBBER -- requirements
Module: hamming_scrubber

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the saturating error counters.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  in_data/in_check are valid this cycle.
REQ-005 SHALL have port in_data  input  64  protected counter value from the counter stage.
REQ-006 SHALL have port in_check  input  8  stored check bits; [6:0] Hamming, [7] overall parity.
REQ-007 SHALL have port out_valid  output  1  out_data is valid this cycle.
REQ-008 SHALL have port out_data  output  64  corrected counter value.
REQ-009 SHALL have port sbe  output  1  one-cycle pulse, aligned with out_valid, single-bit error corrected.
REQ-010 SHALL have port dbe  output  1  one-cycle pulse, aligned with out_valid, uncorrectable error.
REQ-011 SHALL have port wb_valid  output  1  write-back request to the counter stage.
REQ-012 SHALL have port wb_data  output  64  corrected data for write-back.
REQ-013 SHALL have port wb_check  output  8  check bits recomputed from wb_data.
REQ-014 SHALL have port wb_ready  input  1  counter stage accepts the write-back.
REQ-015 SHALL have port err_clr  input  1  synchronous clear of counters and sticky flags.
REQ-016 SHALL have ports sbe_count and dbe_count  output  CNT_W  saturating error totals.
REQ-017 SHALL have ports dbe_sticky and wb_overrun  output  1  sticky error flags.

Function
REQ-018 SHALL use a (72,64) SECDED code: positions 1..71; check bit i at position 2^i (i=0..6); in_data[0..63] at non-power-of-two positions in ascending order (in_data[0] at position 3).
REQ-019 SHALL define check[i] as the XOR of all data positions whose index has bit i set, and check[7] as the XOR of all 71 code bits.
REQ-020 Stage 1 SHALL register the syndrome s[6:0] (recomputed check XOR in_check[6:0]), the overall parity p over all 72 received bits, and the raw word, when in_valid=1.
REQ-021 Stage 2 SHALL register the classification and the corrected data; out_valid SHALL assert exactly 2 cycles after in_valid, back-to-back inputs at full rate, no backpressure.
REQ-022 s=0, p=0: no error; out_data=in_data; sbe=dbe=0.
REQ-023 p=1, s=0: error in check[7]; out_data=in_data; sbe=1.
REQ-024 p=1, s a power of two: error in a check bit; out_data=in_data; sbe=1.
REQ-025 p=1, s in 3..71 and not a power of two: flip the data bit at position s; sbe=1.
REQ-026 p=1, s>71, or s!=0 with p=0: dbe=1; out_data=in_data unmodified; no write-back.
REQ-027 Write-back FSM SHALL have states IDLE and REQ; in IDLE, on sbe, load wb_data=out_data, recompute wb_check, go to REQ.
REQ-028 In REQ, wb_valid=1 and wb_data/wb_check SHALL hold stable until the cycle wb_ready=1, then return to IDLE.
REQ-029 An sbe while in REQ, including in the cycle wb_ready=1, SHALL be dropped and SHALL set wb_overrun.
REQ-030 Counters SHALL increment on sbe/dbe and saturate at 2^CNT_W-1.
REQ-031 When err_clr and an event occur in the same cycle, the counter SHALL become 1; a sticky flag SHALL be set.
REQ-032 err_clr SHALL NOT affect the pipeline or the write-back FSM.

Reset
REQ-033 rst SHALL asynchronously force out_valid, sbe, dbe, wb_valid, dbe_sticky and wb_overrun to 0, out_data, wb_data and wb_check to 0, counters to 0, FSM to IDLE, and drop in-flight pipeline data.
REQ-034 Outputs SHALL resume correct behaviour from the first rising edge after rst deasserts; rst during REQ SHALL abandon the request.

Verification
REQ-035 Clean word 0x0000_0000_0000_000A with correct check -> out_valid 2 cycles later, out_data=0x...0A, sbe=dbe=0, counters 0.
REQ-036 Same word with in_data[0] flipped -> out_data=0x...0A, sbe=1, sbe_count=1, wb_valid=1 until wb_ready; wb_check equals the clean check.
REQ-037 in_check[0] flipped -> sbe=1, out_data unchanged, write-back issued with corrected check.
REQ-038 in_data[7] and in_data[8] flipped -> dbe=1, dbe_sticky=1, dbe_count=1, no wb_valid.
REQ-039 Two sbe words 1 cycle apart with wb_ready=0 -> one write-back, wb_overrun=1, sbe_count=2; err_clr -> counts 0, flags 0.
REQ-040 256+ sbe events with CNT_W=8 -> sbe_count holds 255; rst asserted mid-REQ -> wb_valid=0 immediately.
